// File: rtl/lcd_share_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : lcd_share_arbiter_if
// Brief    : Requester handshake and character-LCD bus bundle for the arbiter.
// Revision : 1.0
// =============================================================================
interface lcd_share_arbiter_if;
    logic [1:0] req;
    logic [7:0] char_data0;
    logic [7:0] char_data1;
    logic [1:0] grant;
    logic [4:0] char_idx;
    logic       frame_done;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport slave (
        input  req, char_data0, char_data1,
        output grant, char_idx, frame_done, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );

    modport master (
        output req, char_data0, char_data1,
        input  grant, char_idx, frame_done, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );
endinterface
`default_nettype wire

// File: rtl/lcd_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : lcd_share_arbiter
// Brief    : Owns the character-LCD bus; runs init, then draws whole 2x16
//            frames for two requesters under round-robin arbitration.
// Revision : 1.0
// =============================================================================
module lcd_share_arbiter #(
    parameter int HOLD     = 4,
    parameter int PWR_WAIT = 70,
    parameter int CLR_WAIT = 200
) (
    input  wire                 CLK,
    input  wire                 RESETN,
    lcd_share_arbiter_if.slave  bus
);
    localparam int CW = 16;
    localparam int SW = $clog2(HOLD);

    localparam logic [3:0] S_PWR     = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_IDLE    = 4'd2;
    localparam logic [3:0] S_CLEAR   = 4'd3;
    localparam logic [3:0] S_CLRWAIT = 4'd4;
    localparam logic [3:0] S_ADDR1   = 4'd5;
    localparam logic [3:0] S_LINE1   = 4'd6;
    localparam logic [3:0] S_ADDR2   = 4'd7;
    localparam logic [3:0] S_LINE2   = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    function automatic logic is_slot(input logic [3:0] s);
        return (s == S_INIT) || (s == S_CLEAR) || (s == S_ADDR1) ||
               (s == S_LINE1) || (s == S_ADDR2) || (s == S_LINE2);
    endfunction

    function automatic logic in_frame(input logic [3:0] s);
        return (s == S_CLEAR) || (s == S_CLRWAIT) || (s == S_ADDR1) ||
               (s == S_LINE1) || (s == S_ADDR2) || (s == S_LINE2);
    endfunction

    logic [3:0]    r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [SW-1:0] r_slot, w_slot_next;
    logic          r_last, r_force_clr;
    logic [1:0]    r_grant, w_grant_next;
    logic [7:0]    r_data, w_data_next, w_cmd, w_char;
    logic          r_rs, w_rs_next;
    logic          r_e, w_e_next;
    logic [4:0]    r_char_idx, w_idx_next;
    logic          r_frame_done, w_done_next;
    logic          w_in_slot, w_slot_end, w_pick, w_need_clear, w_start_grant;
    logic          w_next_in_slot;

    assign w_in_slot     = is_slot(r_state);
    assign w_slot_end    = w_in_slot && (r_slot == SW'(HOLD - 1));
    assign w_start_grant = (r_state == S_IDLE) && (bus.req != 2'b00);
    assign w_char        = r_grant[1] ? bus.char_data1 : bus.char_data0;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_pick = 1'b0;
        case (bus.req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last;
            default: w_pick = 1'b0;
        endcase
        w_need_clear = (w_pick != r_last) || r_force_clr;
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            r_state      <= S_PWR;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_last       <= 1'b1;
            r_force_clr  <= 1'b1;
            r_grant      <= 2'b00;
            r_data       <= 8'h00;
            r_rs         <= 1'b0;
            r_e          <= 1'b0;
            r_char_idx   <= 5'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_slot       <= w_slot_next;
            r_grant      <= w_grant_next;
            r_data       <= w_data_next;
            r_rs         <= w_rs_next;
            r_e          <= w_e_next;
            r_char_idx   <= w_idx_next;
            r_frame_done <= w_done_next;
            if (w_start_grant) begin
                r_last <= w_pick;
            end
            if (r_state == S_CLEAR) begin
                r_force_clr <= 1'b0;
            end
        end
    end

    // r_cnt is the wait counter in PWR/CLRWAIT and the slot index elsewhere.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_slot_next  = (w_in_slot && !w_slot_end) ? r_slot + 1'b1 : '0;
        case (r_state)
            S_PWR: begin
                if (r_cnt == CW'(PWR_WAIT - 1)) begin
                    w_state_next = S_INIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_INIT: begin
                if (w_slot_end) begin
                    if (r_cnt == CW'(2)) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (w_start_grant) begin
                    w_state_next = w_need_clear ? S_CLEAR : S_ADDR1;
                    w_cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                if (w_slot_end) begin
                    w_state_next = (CLR_WAIT == 0) ? S_ADDR1 : S_CLRWAIT;
                    w_cnt_next   = '0;
                end
            end
            S_CLRWAIT: begin
                if (r_cnt == CW'(CLR_WAIT - 1)) begin
                    w_state_next = S_ADDR1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_ADDR1: begin
                if (w_slot_end) begin
                    w_state_next = S_LINE1;
                    w_cnt_next   = '0;
                end
            end
            S_LINE1: begin
                if (w_slot_end) begin
                    if (r_cnt == CW'(15)) begin
                        w_state_next = S_ADDR2;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_ADDR2: begin
                if (w_slot_end) begin
                    w_state_next = S_LINE2;
                    w_cnt_next   = '0;
                end
            end
            S_LINE2: begin
                if (w_slot_end) begin
                    if (r_cnt == CW'(15)) begin
                        w_state_next = S_DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = S_PWR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output registers are loaded with the values for the upcoming cycle.
    always_comb begin
        w_grant_next = r_grant;
        if (w_start_grant) begin
            w_grant_next = w_pick ? 2'b10 : 2'b01;
        end else if (!in_frame(w_state_next)) begin
            w_grant_next = 2'b00;
        end

        w_cmd = 8'h00;
        case (w_state_next)
            S_INIT: begin
                if (w_cnt_next == '0) begin
                    w_cmd = 8'h3C;
                end else if (w_cnt_next == CW'(1)) begin
                    w_cmd = 8'h0C;
                end else begin
                    w_cmd = 8'h06;
                end
            end
            S_CLEAR: w_cmd = 8'h01;
            S_ADDR1: w_cmd = 8'h80;
            S_ADDR2: w_cmd = 8'hC0;
            S_LINE1, S_LINE2: w_cmd = w_char;
            default: w_cmd = 8'h00;
        endcase

        w_next_in_slot = is_slot(w_state_next);
        if (w_next_in_slot && (w_slot_next == '0)) begin
            w_data_next = w_cmd;
        end else if (w_next_in_slot) begin
            w_data_next = r_data;
        end else begin
            w_data_next = 8'h00;
        end
        w_rs_next = (w_state_next == S_LINE1) || (w_state_next == S_LINE2);
        w_e_next  = w_next_in_slot && (w_slot_next != '0) &&
                    (w_slot_next <= SW'(HOLD - 2));

        // The index moves during the last cycle of a slot so the requester's
        // data has settled before the next slot-start edge samples it.
        w_idx_next = r_char_idx;
        if (w_in_slot && (r_slot == SW'(HOLD - 2))) begin
            case (r_state)
                S_LINE1: w_idx_next = (r_cnt[3:0] == 4'd15) ? 5'd0 :
                                      {1'b0, r_cnt[3:0]} + 5'd1;
                S_ADDR2: w_idx_next = 5'd16;
                S_LINE2: w_idx_next = (r_cnt[3:0] == 4'd15) ? 5'd0 :
                                      {1'b0, r_cnt[3:0]} + 5'd17;
                default: w_idx_next = 5'd0;
            endcase
        end

        w_done_next = (w_state_next == S_DONE);
    end

    assign bus.grant      = r_grant;
    assign bus.char_idx   = r_char_idx;
    assign bus.frame_done = r_frame_done;
    assign bus.LCD_E      = r_e;
    assign bus.LCD_RS     = r_rs;
    assign bus.LCD_RW     = 1'b0;
    assign bus.LCD_DATA   = r_data;
endmodule
`default_nettype wire

// File: tb/tb_lcd_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_lcd_share_arbiter
// Brief    : Self-checking bench for lcd_share_arbiter with a frame-level model.
// Revision : 1.0
// =============================================================================
module tb_lcd_share_arbiter;
    localparam int HOLD     = 4;
    localparam int PWR_WAIT = 70;
    localparam int CLR_WAIT = 200;

    logic CLK;
    logic RESETN;
    lcd_share_arbiter_if bus();

    logic [7:0] msg0 [0:31];
    logic [7:0] msg1 [0:31];
    assign bus.char_data0 = msg0[bus.char_idx];
    assign bus.char_data1 = msg1[bus.char_idx];

    lcd_share_arbiter #(.HOLD(HOLD), .PWR_WAIT(PWR_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;
    bit m_last  = 1'b1;
    bit m_force = 1'b1;
    int t0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         t_rise;
        int         width;
        bit         stable;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        cur;
    int         grant_t_q[$];
    logic [1:0] grant_v_q[$];
    int         done_t_q[$];
    logic [1:0] done_grant_q[$];
    logic       prev_e = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    // Bus monitor: one record per E pulse, plus grant-rise and frame_done events.
    always @(negedge CLK) begin
        if (bus.LCD_E === 1'b1 && prev_e !== 1'b1) begin
            cur.rs = bus.LCD_RS; cur.data = bus.LCD_DATA;
            cur.t_rise = cyc; cur.width = 1; cur.stable = 1'b1;
        end else if (bus.LCD_E === 1'b1) begin
            cur.width = cur.width + 1;
            if (bus.LCD_RS !== cur.rs || bus.LCD_DATA !== cur.data) cur.stable = 1'b0;
        end else if (prev_e === 1'b1) begin
            wr_q.push_back(cur);
        end
        if (bus.grant !== 2'b00 && prev_grant === 2'b00) begin
            grant_t_q.push_back(cyc);
            grant_v_q.push_back(bus.grant);
        end
        if (bus.frame_done === 1'b1) begin
            done_t_q.push_back(cyc);
            done_grant_q.push_back(bus.grant);
        end
        prev_e     = bus.LCD_E;
        prev_grant = bus.grant;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete(); grant_t_q.delete(); grant_v_q.delete();
        done_t_q.delete(); done_grant_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] init_cmd [0:2];
        init_cmd[0] = 8'h3C; init_cmd[1] = 8'h0C; init_cmd[2] = 8'h06;
        bus.req = 2'b00;
        tick(); RESETN = 1'b1; tick(); tick(); RESETN = 1'b0;
        t0 = cyc; clear_logs(); m_last = 1'b1; m_force = 1'b1;
        checks++; if (bus.LCD_E !== 1'b0) begin errors++; $display("FAIL rst_e: got %b expected 0", bus.LCD_E); end
        checks++; if (bus.LCD_RS !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b expected 0", bus.LCD_RS); end
        checks++; if (bus.LCD_RW !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b expected 0", bus.LCD_RW); end
        checks++; if (bus.LCD_DATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", bus.LCD_DATA); end
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b expected 00", bus.grant); end
        checks++; if (bus.char_idx !== 5'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", bus.char_idx); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.frame_done); end
        for (int i = 0; i < 400; i++) tick();
        checks++;
        if (wr_q.size() != 3) begin
            errors++; $display("FAIL init_count: got %0d writes expected 3", wr_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wr_q[k].rs !== 1'b0 || wr_q[k].data !== init_cmd[k] || wr_q[k].width != HOLD - 2 ||
                    !wr_q[k].stable || wr_q[k].t_rise != t0 + PWR_WAIT + 1 + k * HOLD) begin
                    errors++;
                    $display("FAIL init_write%0d: got rs=%b data=%h width=%0d rise=%0d expected rs=0 data=%h width=%0d rise=%0d",
                             k, wr_q[k].rs, wr_q[k].data, wr_q[k].width, wr_q[k].t_rise - t0,
                             init_cmd[k], HOLD - 2, PWR_WAIT + 1 + k * HOLD);
                end
            end
        end
        checks++;
        if (grant_t_q.size() != 0) begin errors++; $display("FAIL init_grant: got %0d grants expected 0", grant_t_q.size()); end
        checks++;
        if ({bus.LCD_E, bus.LCD_RS, bus.LCD_DATA} !== 10'h000) begin
            errors++; $display("FAIL idle_bus: got e=%b rs=%b data=%h expected 0 0 00", bus.LCD_E, bus.LCD_RS, bus.LCD_DATA);
        end
        clear_logs();
    endtask

    // Draws one frame and compares it with the frame-level expectation.
    task automatic run_frame(input logic [1:0] rq, input int drop_idx, input string name);
        bit         owner, exp_clr;
        logic [1:0] exp_g;
        int         exp_lat, lat, n, bad, first_bad;
        logic [8:0] exp_w[$];
        logic [7:0] snap [0:31];
        owner   = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : ~m_last;
        exp_clr = (owner != m_last) || m_force;
        m_last  = owner;
        if (exp_clr) m_force = 1'b0;
        exp_g   = owner ? 2'b10 : 2'b01;
        exp_lat = exp_clr ? 35 * HOLD + CLR_WAIT + 1 : 34 * HOLD + 1;
        for (int i = 0; i < 32; i++) snap[i] = owner ? msg1[i] : msg0[i];
        if (exp_clr) exp_w.push_back({1'b0, 8'h01});
        exp_w.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_w.push_back({1'b1, snap[i]});
        exp_w.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_w.push_back({1'b1, snap[i]});

        bus.req = rq;
        n = 0;
        while (done_t_q.size() == 0 && n < 2000) begin
            tick(); n++;
            if (drop_idx >= 0 && bus.char_idx == 5'(drop_idx)) bus.req = 2'b00;
        end
        checks++;
        if (done_t_q.size() == 0) begin
            errors++; $display("FAIL %s_timeout: no frame_done after %0d cycles", name, n);
            clear_logs();
            return;
        end
        checks++;
        if (grant_v_q.size() != 1 || grant_v_q[0] !== exp_g) begin
            errors++;
            $display("FAIL %s_grant: got %b (%0d grant events) expected %b", name,
                     (grant_v_q.size() > 0) ? grant_v_q[0] : 2'bxx, grant_v_q.size(), exp_g);
        end
        lat = (grant_t_q.size() > 0) ? done_t_q[0] - grant_t_q[0] + 1 : -1;
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (done_grant_q[0] !== 2'b00) begin
            errors++; $display("FAIL %s_done_grant: got %b expected 00", name, done_grant_q[0]);
        end
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++; $display("FAIL %s_write_count: got %0d expected %0d", name, wr_q.size(), exp_w.size());
        end else begin
            bad = 0; first_bad = -1;
            for (int k = 0; k < exp_w.size(); k++) begin
                if ({wr_q[k].rs, wr_q[k].data} !== exp_w[k] || wr_q[k].width != HOLD - 2 || !wr_q[k].stable) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_writes: %0d bad, first #%0d got rs=%b data=%h width=%0d stable=%0d expected rs=%b data=%h width=%0d",
                         name, bad, first_bad, wr_q[first_bad].rs, wr_q[first_bad].data, wr_q[first_bad].width,
                         wr_q[first_bad].stable, exp_w[first_bad][8], exp_w[first_bad][7:0], HOLD - 2);
            end
        end
        clear_logs();
    endtask

    task automatic test_first_frame();
        string s;
        s = "Player1 turn";
        for (int i = 0; i < 32; i++) msg0[i] = (i < s.len()) ? s[i] : 8'h20;
        run_frame(2'b01, -1, "first_frame");
    endtask

    task automatic test_same_owner();
        run_frame(2'b01, -1, "same_owner");
    endtask

    task automatic test_alternate();
        for (int f = 0; f < 4; f++) run_frame(2'b11, -1, "alternate");
    endtask

    task automatic test_back_to_back();
        logic [1:0] rq;
        for (int f = 0; f < 8; f++) begin
            rq = 2'($urandom_range(1, 3));
            for (int i = 0; i < 32; i++) begin
                msg0[i] = 8'($urandom_range(32, 126));
                msg1[i] = 8'($urandom_range(32, 126));
            end
            run_frame(rq, -1, "random");
        end
    endtask

    task automatic test_req_drop();
        run_frame(2'b01, 20, "req_drop");
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (grant_t_q.size() != 0 || wr_q.size() != 0 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL drop_idle: got %0d grants %0d writes grant=%b expected 0 0 00",
                     grant_t_q.size(), wr_q.size(), bus.grant);
        end
        clear_logs();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bus.req = 2'b01;
        n = 0;
        while (bus.char_idx !== 5'd18 && n < 2000) begin tick(); n++; end
        checks++;
        if (bus.char_idx !== 5'd18) begin
            errors++; $display("FAIL midrst_reach: got char_idx=%0d expected 18", bus.char_idx);
        end
        RESETN = 1'b1; bus.req = 2'b00;
        tick();
        RESETN = 1'b0;
        t0 = cyc; clear_logs(); m_last = 1'b1; m_force = 1'b1;
        checks++;
        if ({bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA, bus.grant, bus.char_idx, bus.frame_done} !== 19'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got e=%b rs=%b rw=%b data=%h grant=%b idx=%0d done=%b expected all zero",
                     bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA, bus.grant, bus.char_idx, bus.frame_done);
        end
        for (int i = 0; i < PWR_WAIT + 3 * HOLD + 20; i++) tick();
        checks++;
        if (wr_q.size() != 3 || wr_q[0].data !== 8'h3C || wr_q[1].data !== 8'h0C || wr_q[2].data !== 8'h06 ||
            wr_q[0].t_rise != t0 + PWR_WAIT + 1) begin
            errors++;
            $display("FAIL midrst_init: got %0d writes first=%h rise=%0d expected 3 writes first=3C rise=%0d",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].data : 8'hxx,
                     (wr_q.size() > 0) ? wr_q[0].t_rise - t0 : -1, PWR_WAIT + 1);
        end
        clear_logs();
        run_frame(2'b10, -1, "post_reset");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN  = 1'b1;
        bus.req = 2'b00;
        for (int i = 0; i < 32; i++) begin
            msg0[i] = 8'h20;
            msg1[i] = 8'h41 + 8'(i % 26);
        end
        test_reset();
        test_first_frame();
        test_same_owner();
        test_alternate();
        test_back_to_back();
        test_req_drop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
